// File: rtl/tmcu_ahb_pkg.sv
// Shared AHB-Lite types, response codes and the default T-MCU address map.
package tmcu_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } dflt_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] SRAM_BASE = 32'h2000_0000;
  localparam logic [31:0] SRAM_MASK = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_BASE = 32'h4000_0000;
  localparam logic [31:0] GPIO_MASK = 32'hFFFF_F000;
  localparam logic [31:0] UART_BASE = 32'h4000_1000;
  localparam logic [31:0] UART_MASK = 32'hFFFF_F000;

  localparam logic [127:0] DEFAULT_SLV_BASE = {UART_BASE, GPIO_BASE, SRAM_BASE, ROM_BASE};
  localparam logic [127:0] DEFAULT_SLV_MASK = {UART_MASK, GPIO_MASK, SRAM_MASK, ROM_MASK};

endpackage

// File: rtl/tmcu_ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR for unmapped accesses; with
// TMCU_FABRIC_TIMEOUT_EN it also aborts slaves that stall too long.
//
// state   | meaning
// DS_IDLE | no error response in progress
// DS_ERR1 | first ERROR cycle, HREADY low
// DS_ERR2 | second ERROR cycle, HREADY high, next owner loads
module tmcu_ahb_default_slave
  import tmcu_ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic stall_i,
  input  logic hready_i,
  output logic active_o,
  output logic hready_o,
  output logic hresp_o,
  output logic timeout_irq_o
);

  dflt_state_e state_q, state_d;
  logic        tmo_hit;

`ifdef TMCU_FABRIC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q;

  // Count only while a real slave is stalling, not while we own the bus.
  always_comb begin
    cnt_d   = cnt_q;
    tmo_hit = 1'b0;
    if (hready_i) begin
      cnt_d = '0;
    end else if (stall_i && (state_q == DS_IDLE)) begin
      cnt_d   = cnt_q + CNT_W'(1);
      tmo_hit = (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_hit;
    end
  end

  assign timeout_irq_o = tmo_q;
`else
  logic unused_cfg;
  assign unused_cfg    = ^{stall_i, hready_i, (TIMEOUT_CYCLES != 0)};
  assign tmo_hit       = 1'b0;
  assign timeout_irq_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE: if (load_i || tmo_hit) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = load_i ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= DS_IDLE;
    else       state_q <= state_d;
  end

  assign active_o = (state_q != DS_IDLE);
  assign hready_o = (state_q == DS_ERR2);
  assign hresp_o  = active_o ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/tmcu_ahb_fabric.sv
// Single-master AHB-Lite interconnect: address decode, data-phase owner and
// response mux. Optional slave timeout via TMCU_FABRIC_TIMEOUT_EN.
module tmcu_ahb_fabric
  import tmcu_ahb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = DEFAULT_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = DEFAULT_SLV_MASK,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_W-1:0]            m_haddr_i,
  input  logic [1:0]                   m_htrans_i,
  input  logic                         m_hwrite_i,
  input  logic [2:0]                   m_hsize_i,
  input  logic [DATA_W-1:0]            m_hwdata_i,
  output logic [DATA_W-1:0]            m_hrdata_o,
  output logic                         m_hready_o,
  output logic                         m_hresp_o,
  output logic [NUM_SLAVES-1:0]        s_hsel_o,
  output logic [ADDR_W-1:0]            s_haddr_o,
  output logic [1:0]                   s_htrans_o,
  output logic                         s_hwrite_o,
  output logic [2:0]                   s_hsize_o,
  output logic [DATA_W-1:0]            s_hwdata_o,
  output logic                         s_hready_o,
  input  logic [NUM_SLAVES-1:0]        s_hreadyout_i,
  input  logic [NUM_SLAVES-1:0]        s_hresp_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_hrdata_i,
  output logic                         timeout_irq_o
);

  // Owner codes: 0..NUM_SLAVES-1 are slaves, then DEFAULT, then NONE.
  localparam int unsigned DSEL_W = $clog2(NUM_SLAVES + 2);
  localparam logic [DSEL_W-1:0] DSEL_DEFAULT = DSEL_W'(NUM_SLAVES);
  localparam logic [DSEL_W-1:0] DSEL_NONE    = DSEL_W'(NUM_SLAVES + 1);

  htrans_e             htrans;
  logic                active;
  logic                hit;
  logic [DSEL_W-1:0]   win_idx;
  logic [NUM_SLAVES-1:0] win_oh;
  logic [DSEL_W-1:0]   dsel_q, dsel_d;
  logic                slv_hready, slv_hresp, slv_stall;
  logic [DATA_W-1:0]   slv_hrdata;
  logic                dflt_active, dflt_hready, dflt_hresp, dflt_load;

  assign htrans = htrans_e'(m_htrans_i);
  assign active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

  // Scan high to low so the lowest matching index is left standing.
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((m_haddr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit       = 1'b1;
        win_idx   = DSEL_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign s_hsel_o = active ? win_oh : '0;

  always_comb begin
    dsel_d = dsel_q;
    if (m_hready_o) begin
      if (!active)  dsel_d = DSEL_NONE;
      else if (hit) dsel_d = win_idx;
      else          dsel_d = DSEL_DEFAULT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dsel_q <= DSEL_NONE;
    else       dsel_q <= dsel_d;
  end

  always_comb begin
    slv_hready = 1'b1;
    slv_hresp  = HRESP_OKAY;
    slv_hrdata = '0;
    slv_stall  = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (dsel_q == DSEL_W'(i)) begin
        slv_hready = s_hreadyout_i[i];
        slv_hresp  = s_hresp_i[i];
        slv_hrdata = s_hrdata_i[i*DATA_W +: DATA_W];
        slv_stall  = ~s_hreadyout_i[i];
      end
    end
  end

  assign dflt_load = m_hready_o & active & ~hit;

  tmcu_ahb_default_slave #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_default_slave (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_i        (dflt_load),
    .stall_i       (slv_stall),
    .hready_i      (m_hready_o),
    .active_o      (dflt_active),
    .hready_o      (dflt_hready),
    .hresp_o       (dflt_hresp),
    .timeout_irq_o (timeout_irq_o)
  );

  assign m_hready_o = dflt_active ? dflt_hready : slv_hready;
  assign m_hresp_o  = dflt_active ? dflt_hresp  : slv_hresp;
  assign m_hrdata_o = dflt_active ? '0          : slv_hrdata;

  assign s_haddr_o  = m_haddr_i;
  assign s_htrans_o = m_htrans_i;
  assign s_hwrite_o = m_hwrite_i;
  assign s_hsize_o  = m_hsize_i;
  assign s_hwdata_o = m_hwdata_i;
  assign s_hready_o = m_hready_o;

endmodule
